eth_rx_drain_ctrl: RTL and testbench
====================================

ETH_RX_DRAIN_CTRL -- requirements
Module: eth_rx_drain_ctrl

Interface
REQ-001 Parameter P_SLOT_BYTES, 1024, byte size of one packet slot in receive memory.
REQ-002 Parameter P_MAX_SLOTS, 62, highest packet count the receive engine reports.
REQ-003 i_eth_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_packet_count  in  10  number of valid packets held in receive memory.
REQ-006 i_rx_busy  in  1  receive engine mid-frame.
REQ-007 i_valid_packet  in  1  one-cycle pulse, packet accepted; i_packet_count already holds post-increment value.
REQ-008 i_pkt_len  in  16  byte count of the packet flagged by i_valid_packet.
REQ-009 o_mem_rd_addr  out  16  receive-memory read address.
REQ-010 o_mem_rd_en  out  1  read strobe; data returns on i_mem_rd_data one cycle later.
REQ-011 i_mem_rd_data  in  8  read data.
REQ-012 o_data / o_data_valid / o_data_last  out  8/1/1  byte stream to consumer; last marks final byte of a packet.
REQ-013 i_data_ready  in  1  consumer accepts byte when valid and ready are both high.
REQ-014 o_rst_waddr  out  1  level request to receive engine to clear its write address and packet count.
REQ-015 o_busy  out  1  high in every state except S_IDLE.
REQ-016 o_drained_count  out  10  packets fully emitted since last clear.

Function
REQ-017 Length table of 64 x 16 bits SHALL be written at index i_packet_count-1 on each i_valid_packet, with i_pkt_len clamped to P_SLOT_BYTES.
REQ-018 States: S_IDLE, S_RD_REQ, S_RD_WAIT, S_OUT, S_NEXT_PKT, S_CLR_REQ, S_CLR_WAIT.
REQ-019 S_IDLE: if rd_slot < i_packet_count -> load byte counter from table[rd_slot], o_mem_rd_addr = rd_slot*P_SLOT_BYTES, go S_RD_REQ; a zero length goes directly to S_NEXT_PKT.
REQ-020 S_IDLE: else if i_packet_count != 0, rd_slot == i_packet_count and i_rx_busy low -> S_CLR_REQ.
REQ-021 S_RD_REQ: o_mem_rd_en high exactly one cycle -> S_RD_WAIT.
REQ-022 S_RD_WAIT: register i_mem_rd_data into o_data, raise o_data_valid -> S_OUT.
REQ-023 S_OUT: o_data/o_data_valid/o_data_last SHALL hold stable until handshake; on handshake advance address by 1, decrement byte counter; counter reaches 0 -> S_NEXT_PKT, else S_RD_REQ.
REQ-024 o_data_last SHALL be high only with the byte for which the byte counter equals 1.
REQ-025 S_NEXT_PKT: rd_slot +1, o_drained_count +1 (saturating at 1023) -> S_IDLE.
REQ-026 S_CLR_REQ: o_rst_waddr high; hold until i_packet_count == 0 -> S_CLR_WAIT.
REQ-027 S_CLR_WAIT: o_rst_waddr low, rd_slot and o_drained_count cleared -> S_IDLE after 2 cycles (engine synchroniser depth).
REQ-028 i_valid_packet arriving in any state SHALL still update the table; it is never dropped.
REQ-029 If i_rx_busy rises during S_CLR_REQ, o_rst_waddr SHALL remain high; the clear completes when the engine returns to idle.
REQ-030 Address arithmetic 16-bit unsigned; slot base = rd_slot shifted left 10; no wrap past slot end because length is clamped.
REQ-031 Idle-to-first-byte latency: 3 cycles (S_IDLE, S_RD_REQ, S_RD_WAIT); steady throughput one byte per 3 cycles with ready held high.

Reset
REQ-032 On i_rst_n low, asynchronously: state S_IDLE, rd_slot 0, all outputs 0, o_drained_count 0; length table contents undefined.
REQ-033 Reset mid-packet SHALL abandon the packet with no further o_data_valid after release.

Structure
REQ-034 Shared package holds state enumeration, P_SLOT_BYTES, P_MAX_SLOTS, and the slot-shift constant 10.
REQ-035 Length table SHALL be a sub-module eth_len_ram (1 write port, 1 asynchronous read port, 64 x 16).

Verification
REQ-036 One packet, len 4, bytes 11 22 33 44 at address 0, ready high -> four beats 11,22,33,44, last on 44, o_drained_count 1.
REQ-037 Same packet, ready toggled 1-0-1-0 -> identical byte order, data stable while ready low, no duplicates.
REQ-038 Two packets (len 3, len 1) -> second read starts at address 1024, two last pulses, then o_rst_waddr high until count 0, rd_slot 0.
REQ-039 Count 1, i_rx_busy held high after drain -> o_rst_waddr stays low until busy falls.
REQ-040 i_pkt_len 0 -> no o_data_valid, o_drained_count increments; i_pkt_len 2000 -> exactly 1024 bytes emitted.
REQ-041 i_rst_n pulsed low during byte 2 of len-8 packet -> outputs 0 immediately, no beats after release until count reloads.

Source files
------------

// File: rtl/eth_rx_drain_ctrl_pkg.sv
// Shared constants, state encoding and slot-address helper for the receive-memory
// drain controller and its length table.
package eth_rx_drain_ctrl_pkg;

   localparam int SLOT_BYTES = 1024;
   localparam int MAX_SLOTS  = 62;
   localparam int SLOT_SHIFT = 10;
   localparam int LEN_DEPTH  = 64;
   localparam int LEN_AW     = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_OUT,
      S_NEXT_PKT,
      S_CLR_REQ,
      S_CLR_WAIT
   } drain_state_t;

   // Byte address of the first byte of a packet slot.
   function automatic logic [15:0] slot_base(input logic [LEN_AW-1:0] slot);
      return {slot, {SLOT_SHIFT{1'b0}}};
   endfunction

endpackage

// File: rtl/eth_len_ram.sv
// Per-slot packet length table: one synchronous write port, one asynchronous read port.
module eth_len_ram
   import eth_rx_drain_ctrl_pkg::*;
(
   input  logic              i_eth_clk,
   input  logic              wr_en,
   input  logic [LEN_AW-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic [LEN_AW-1:0] rd_addr,
   output logic [15:0]       rd_data
);

   logic [15:0] len_mem [LEN_DEPTH];

   always_ff @(posedge i_eth_clk) begin
      if (wr_en) begin
         len_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = len_mem[rd_addr];

endmodule

// File: rtl/eth_rx_drain_ctrl.sv
// Drains packets from receive memory slot by slot as a byte stream, then asks the
// receive engine to clear its write address once every reported packet is emitted.
module eth_rx_drain_ctrl
   import eth_rx_drain_ctrl_pkg::*;
#(
   parameter int P_SLOT_BYTES = SLOT_BYTES,
   parameter int P_MAX_SLOTS  = MAX_SLOTS
)(
   input  logic        i_eth_clk,
   input  logic        i_rst_n,
   input  logic [9:0]  i_packet_count,
   input  logic        i_rx_busy,
   input  logic        i_valid_packet,
   input  logic [15:0] i_pkt_len,
   output logic [15:0] o_mem_rd_addr,
   output logic        o_mem_rd_en,
   input  logic [7:0]  i_mem_rd_data,
   output logic [7:0]  o_data,
   output logic        o_data_valid,
   output logic        o_data_last,
   input  logic        i_data_ready,
   output logic        o_rst_waddr,
   output logic        o_busy,
   output logic [9:0]  o_drained_count
);

   localparam logic [15:0] SLOT_BYTES_W = 16'(P_SLOT_BYTES);
   localparam logic [9:0]  MAX_SLOTS_W  = 10'(P_MAX_SLOTS);

   drain_state_t state_reg, state_next;
   logic [9:0]   rd_slot_reg, rd_slot_next;
   logic [10:0]  byte_cnt_reg, byte_cnt_next;
   logic [15:0]  addr_reg, addr_next;
   logic [7:0]   data_reg, data_next;
   logic         valid_reg, valid_next;
   logic         last_reg, last_next;
   logic [9:0]   drained_reg, drained_next;
   logic         clr_cnt_reg, clr_cnt_next;

   logic              len_wr_en;
   logic [LEN_AW-1:0] len_wr_addr;
   logic [15:0]       len_wr_data;
   logic [15:0]       len_rd_data;
   logic [15:0]       cur_len;

   assign len_wr_en   = i_valid_packet && (i_packet_count != '0) && (i_packet_count <= MAX_SLOTS_W);
   assign len_wr_addr = LEN_AW'(i_packet_count - 10'd1);
   assign len_wr_data = (i_pkt_len > SLOT_BYTES_W) ? SLOT_BYTES_W : i_pkt_len;

   eth_len_ram u_len_ram (
      .i_eth_clk (i_eth_clk),
      .wr_en     (len_wr_en),
      .wr_addr   (len_wr_addr),
      .wr_data   (len_wr_data),
      .rd_addr   (rd_slot_reg[LEN_AW-1:0]),
      .rd_data   (len_rd_data)
   );

   // The count rises in the same cycle the length is written, so forward it.
   assign cur_len = (len_wr_en && (len_wr_addr == rd_slot_reg[LEN_AW-1:0])) ? len_wr_data : len_rd_data;

   always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= S_IDLE;
         rd_slot_reg  <= '0;
         byte_cnt_reg <= '0;
         addr_reg     <= '0;
         data_reg     <= '0;
         valid_reg    <= 1'b0;
         last_reg     <= 1'b0;
         drained_reg  <= '0;
         clr_cnt_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rd_slot_reg  <= rd_slot_next;
         byte_cnt_reg <= byte_cnt_next;
         addr_reg     <= addr_next;
         data_reg     <= data_next;
         valid_reg    <= valid_next;
         last_reg     <= last_next;
         drained_reg  <= drained_next;
         clr_cnt_reg  <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rd_slot_next  = rd_slot_reg;
      byte_cnt_next = byte_cnt_reg;
      addr_next     = addr_reg;
      data_next     = data_reg;
      valid_next    = valid_reg;
      last_next     = last_reg;
      drained_next  = drained_reg;
      clr_cnt_next  = clr_cnt_reg;

      case (state_reg)
         S_IDLE: begin
            if (rd_slot_reg < i_packet_count) begin
               byte_cnt_next = cur_len[10:0];
               addr_next     = slot_base(rd_slot_reg[LEN_AW-1:0]);
               state_next    = (cur_len == '0) ? S_NEXT_PKT : S_RD_REQ;
            end else if ((i_packet_count != '0) && (rd_slot_reg == i_packet_count) && !i_rx_busy) begin
               state_next = S_CLR_REQ;
            end
         end
         S_RD_REQ: begin
            state_next = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            data_next  = i_mem_rd_data;
            valid_next = 1'b1;
            last_next  = (byte_cnt_reg == 11'd1);
            state_next = S_OUT;
         end
         S_OUT: begin
            if (i_data_ready) begin
               valid_next    = 1'b0;
               last_next     = 1'b0;
               addr_next     = addr_reg + 16'd1;
               byte_cnt_next = byte_cnt_reg - 11'd1;
               state_next    = (byte_cnt_reg == 11'd1) ? S_NEXT_PKT : S_RD_REQ;
            end
         end
         S_NEXT_PKT: begin
            rd_slot_next = rd_slot_reg + 10'd1;
            drained_next = (drained_reg == 10'h3FF) ? drained_reg : drained_reg + 10'd1;
            state_next   = S_IDLE;
         end
         S_CLR_REQ: begin
            // Engine may go busy again here; the request simply stays up until it clears.
            if (i_packet_count == '0) begin
               clr_cnt_next = 1'b0;
               state_next   = S_CLR_WAIT;
            end
         end
         S_CLR_WAIT: begin
            rd_slot_next = '0;
            drained_next = '0;
            clr_cnt_next = 1'b1;
            if (clr_cnt_reg) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign o_mem_rd_addr   = addr_reg;
   assign o_mem_rd_en     = (state_reg == S_RD_REQ);
   assign o_data          = data_reg;
   assign o_data_valid    = valid_reg;
   assign o_data_last     = last_reg;
   assign o_rst_waddr     = (state_reg == S_CLR_REQ);
   assign o_busy          = (state_reg != S_IDLE);
   assign o_drained_count = drained_reg;

endmodule

// File: tb/tb_eth_rx_drain_ctrl.sv
// Scoreboard bench: a model receive engine/memory issues packets and pushes expected
// beats; an independent monitor pops and compares every accepted byte.
module tb_eth_rx_drain_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        i_rst_n;
   logic [9:0]  i_packet_count;
   logic        i_rx_busy;
   logic        i_valid_packet;
   logic [15:0] i_pkt_len;
   logic [15:0] o_mem_rd_addr;
   logic        o_mem_rd_en;
   logic [7:0]  i_mem_rd_data;
   logic [7:0]  o_data;
   logic        o_data_valid;
   logic        o_data_last;
   logic        i_data_ready;
   logic        o_rst_waddr;
   logic        o_busy;
   logic [9:0]  o_drained_count;

   eth_rx_drain_ctrl dut (
      .i_eth_clk       (clk),
      .i_rst_n         (i_rst_n),
      .i_packet_count  (i_packet_count),
      .i_rx_busy       (i_rx_busy),
      .i_valid_packet  (i_valid_packet),
      .i_pkt_len       (i_pkt_len),
      .o_mem_rd_addr   (o_mem_rd_addr),
      .o_mem_rd_en     (o_mem_rd_en),
      .i_mem_rd_data   (i_mem_rd_data),
      .o_data          (o_data),
      .o_data_valid    (o_data_valid),
      .o_data_last     (o_data_last),
      .i_data_ready    (i_data_ready),
      .o_rst_waddr     (o_rst_waddr),
      .o_busy          (o_busy),
      .o_drained_count (o_drained_count)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] rd_addr_log[$];
   logic [7:0]  mem [0:65535];
   int          checks = 0;
   int          failures = 0;
   int          beats_seen = 0;
   int          model_count = 0;
   int          ready_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Receive memory: registered read, data one cycle after the strobe.
   always @(posedge clk) begin
      if (o_mem_rd_en) begin
         i_mem_rd_data <= mem[o_mem_rd_addr];
      end
   end

   initial begin
      i_data_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       i_data_ready = 1'b1;
            1:       i_data_ready = 1'($urandom_range(0, 1));
            default: i_data_ready = ~i_data_ready;
         endcase
      end
   end

   logic       stall_pend = 1'b0;
   logic [7:0] held_data;
   logic       held_last;
   logic       prev_rd_en = 1'b0;
   beat_t      mon_beat;

   always @(negedge clk) begin
      if (!i_rst_n) begin
         stall_pend = 1'b0;
         prev_rd_en = 1'b0;
      end else begin
         if (stall_pend) begin
            check("hold_valid", 32'(o_data_valid), 32'd1);
            check("hold_data", 32'(o_data), 32'(held_data));
            check("hold_last", 32'(o_data_last), 32'(held_last));
         end
         if (o_mem_rd_en) begin
            check("rd_en_single_cycle", 32'(prev_rd_en), 32'd0);
            rd_addr_log.push_back(o_mem_rd_addr);
         end
         prev_rd_en = o_mem_rd_en;
         if (o_data_valid && i_data_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual=%0h required=none", o_data);
            end else begin
               mon_beat = exp_q.pop_front();
               $display("beat data=%02h last=%0d exp=%02h/%0d", o_data, o_data_last, mon_beat.data, mon_beat.last);
               check("beat_data", 32'(o_data), 32'(mon_beat.data));
               check("beat_last", 32'(o_data_last), 32'(mon_beat.last));
            end
         end
         stall_pend = o_data_valid && !i_data_ready;
         held_data  = o_data;
         held_last  = o_data_last;
      end
   end

   // Fill the next slot, queue its expected beats, then pulse valid with the new count.
   task automatic add_packet(input int len, input bit fixed);
      int   n    = (len > 1024) ? 1024 : len;
      int   base = model_count * 1024;
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(0, 255));
         b.last = (i == n - 1);
         mem[16'(base + i)] = b.data;
         exp_q.push_back(b);
      end
      model_count++;
      @(negedge clk);
      i_pkt_len      = 16'(len);
      i_packet_count = 10'(model_count);
      i_valid_packet = 1'b1;
      @(negedge clk);
      i_valid_packet = 1'b0;
   endtask

   task automatic drain_and_clear(input int n_exp);
      int t = 0;
      while (o_rst_waddr !== 1'b1 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check("clr_req_seen", 32'(o_rst_waddr), 32'd1);
      check("all_beats_emitted", 32'(exp_q.size()), 32'd0);
      check("drained_count", 32'(o_drained_count), 32'(n_exp));
      exp_q.delete();
      i_rx_busy = 1'b1;
      repeat (3) @(negedge clk);
      check("clr_req_held_while_busy", 32'(o_rst_waddr), 32'd1);
      i_rx_busy      = 1'b0;
      i_packet_count = '0;
      model_count    = 0;
      t = 0;
      while (o_busy !== 1'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("idle_after_clear", 32'(o_busy), 32'd0);
      check("drained_cleared", 32'(o_drained_count), 32'd0);
      check("rst_waddr_low", 32'(o_rst_waddr), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int t;
      int b0;
      bit stayed_low;
      int npk;

      i_rst_n        = 1'b0;
      i_packet_count = '0;
      i_rx_busy      = 1'b0;
      i_valid_packet = 1'b0;
      i_pkt_len      = '0;
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom_range(0, 255));
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_valid", 32'(o_data_valid), 32'd0);
      check("reset_rst_waddr", 32'(o_rst_waddr), 32'd0);
      check("reset_rd_en", 32'(o_mem_rd_en), 32'd0);
      check("reset_drained", 32'(o_drained_count), 32'd0);
      i_rst_n = 1'b1;
      @(negedge clk);

      // Single packet 11 22 33 44, ready high, with first-byte latency.
      ready_mode = 0;
      add_packet(4, 1'b1);
      lat = 1;
      while (!o_data_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("first_byte_latency", 32'(lat), 32'd3);
      drain_and_clear(1);

      // Same packet with ready toggling every cycle.
      ready_mode = 2;
      add_packet(4, 1'b1);
      drain_and_clear(1);
      ready_mode = 0;

      // Two packets: second read must start at the next slot base.
      i_rx_busy = 1'b1;
      rd_addr_log.delete();
      add_packet(3, 1'b0);
      add_packet(1, 1'b0);
      i_rx_busy = 1'b0;
      drain_and_clear(2);
      check("two_pkt_read_count", 32'(rd_addr_log.size()), 32'd4);
      if (rd_addr_log.size() == 4) begin
         check("slot0_first_addr", 32'(rd_addr_log[0]), 32'd0);
         check("slot1_first_addr", 32'(rd_addr_log[3]), 32'd1024);
      end

      // Engine busy after drain: no clear request until it goes idle.
      i_rx_busy = 1'b1;
      add_packet(6, 1'b0);
      t = 0;
      while ((exp_q.size() != 0 || o_busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      stayed_low = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (o_rst_waddr) stayed_low = 1'b0;
      end
      check("no_clear_while_busy", 32'(stayed_low), 32'd1);
      i_rx_busy = 1'b0;
      drain_and_clear(1);

      // Zero length then an oversize length clamped to one slot.
      i_rx_busy  = 1'b1;
      ready_mode = 1;
      b0 = beats_seen;
      add_packet(0, 1'b0);
      add_packet(2000, 1'b0);
      i_rx_busy = 1'b0;
      drain_and_clear(2);
      check("clamped_beat_count", 32'(beats_seen - b0), 32'd1024);

      // Random batches.
      for (int r = 0; r < 5; r++) begin
         i_rx_busy = 1'b1;
         npk = $urandom_range(1, 4);
         for (int k = 0; k < npk; k++) add_packet($urandom_range(0, 30), 1'b0);
         i_rx_busy = 1'b0;
         drain_and_clear(npk);
      end

      // Reset during byte 2 of a length-8 packet.
      ready_mode = 0;
      i_rx_busy  = 1'b1;
      b0 = beats_seen;
      add_packet(8, 1'b0);
      t = 0;
      while (!(beats_seen == b0 + 1 && o_data_valid) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("reached_byte2", 32'(beats_seen - b0), 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(o_data_valid), 32'd0);
      check("rst_mid_data", 32'(o_data), 32'd0);
      check("rst_mid_last", 32'(o_data_last), 32'd0);
      check("rst_mid_addr", 32'(o_mem_rd_addr), 32'd0);
      check("rst_mid_busy", 32'(o_busy), 32'd0);
      exp_q.delete();
      i_packet_count = '0;
      model_count    = 0;
      i_rx_busy      = 1'b0;
      repeat (3) @(negedge clk);
      i_rst_n = 1'b1;
      b0 = beats_seen;
      repeat (30) @(negedge clk);
      check("no_beats_after_reset", 32'(beats_seen - b0), 32'd0);
      check("idle_after_reset", 32'(o_busy), 32'd0);

      // Normal operation resumes from slot 0.
      add_packet(5, 1'b0);
      drain_and_clear(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
